count_sched: RTL and testbench

- Scheduler that shares one terminal up-counter datapath (count-to-limit, hold-at-limit) among N requesters.
- Round-robin arbitration grants the counter to one requester at a time.
- Loads that requester's limit, sequences the count from 0 to the limit, then reports completion.
- Sits above the counter datapath; requesters are control blocks that need a bounded delay or iteration count.

---
 rtl/count_sched_pkg.sv | 26 ++
 rtl/count_sched_rr_arbiter.sv | 34 +++
 rtl/count_sched.sv | 122 ++++++++++++
 tb/tb_count_sched.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/count_sched_pkg.sv
// Shared types and constants for the counter scheduler and its round-robin arbiter.
// No logic; latency and backpressure are not applicable.
package count_sched_pkg;

    localparam int DEF_N = 4;
    localparam int DEF_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Smallest r with 2**r >= v; used to size requester indices.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << r) < v) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/count_sched_rr_arbiter.sv
// Round-robin pick: first set request at or above ptr, wrapping modulo N.
// Purely combinational (0 cycles); no backpressure, the caller decides when to take the pick.
module rr_arbiter #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   req_i,
    input  logic [IDW-1:0] ptr_i,
    output logic           valid_o,
    output logic [IDW-1:0] sel_o,
    output logic [N-1:0]   onehot_o
);

    int           idx;
    logic [N-1:0] req_shift;

    always_comb begin
        valid_o   = 1'b0;
        sel_o     = '0;
        idx       = 0;
        req_shift = '0;
        for (int k = 0; k < N; k++) begin
            idx       = (int'(ptr_i) + k) % N;
            req_shift = req_i >> idx;
            if (!valid_o && req_shift[0]) begin
                valid_o = 1'b1;
                sel_o   = IDW'(idx);
            end
        end
    end

    assign onehot_o = valid_o ? ({{(N-1){1'b0}}, 1'b1} << sel_o) : '0;

endmodule

// File: rtl/count_sched.sv
// Shares one terminal up-counter among N requesters: grant, count 0..limit, pulse done.
// Grant 1 cycle after request, owned L+2 cycles; requesters hold req (drop = abandon), no queueing.
module count_sched
    import count_sched_pkg::*;
#(
    parameter int N   = DEF_N,
    parameter int W   = DEF_W,
    parameter int IDW = clog2(N)
) (
    input  logic           clock_i,
    input  logic           reset_ni,
    input  logic [N-1:0]   req_i,
    input  logic [N*W-1:0] req_limit_i,
    output logic [N-1:0]   gnt_o,
    output logic           busy_o,
    output logic [W-1:0]   count_o,
    output logic           done_o,
    output logic [IDW-1:0] done_id_o
);

    state_e         state_q;
    logic [N-1:0]   gnt_q;
    logic           busy_q;
    logic [W-1:0]   count_q;
    logic [W-1:0]   count_d;
    logic [W-1:0]   lim_q;
    logic [W-1:0]   lim_d;
    logic [IDW-1:0] sel_q;
    logic [IDW-1:0] ptr_q;
    logic [IDW-1:0] ptr_d;
    logic           done_q;
    logic [IDW-1:0] done_id_q;

    logic           arb_vld;
    logic [IDW-1:0] arb_sel;
    logic [N-1:0]   arb_onehot;

    rr_arbiter #(
        .N   (N),
        .IDW (IDW)
    ) u_arb (
        .req_i    (req_i),
        .ptr_i    (ptr_q),
        .valid_o  (arb_vld),
        .sel_o    (arb_sel),
        .onehot_o (arb_onehot)
    );

    always_comb begin
        lim_d = '0;
        for (int i = 0; i < N; i++) begin
            if (arb_sel == IDW'(i)) begin
                lim_d = req_limit_i[i*W +: W];
            end
        end
    end

    // Only taken while count < lim, so the increment never carries out.
    assign count_d = count_q + {{(W-1){1'b0}}, 1'b1};
    assign ptr_d   = (sel_q == IDW'(N-1)) ? '0 : sel_q + IDW'(1);

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            busy_q    <= 1'b0;
            count_q   <= '0;
            lim_q     <= '0;
            sel_q     <= '0;
            ptr_q     <= '0;
            done_q    <= 1'b0;
            done_id_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (arb_vld) begin
                        gnt_q   <= arb_onehot;
                        sel_q   <= arb_sel;
                        lim_q   <= lim_d;
                        count_q <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (!req_i[sel_q]) begin
                        gnt_q   <= '0;
                        busy_q  <= 1'b0;
                        count_q <= '0;
                        ptr_q   <= ptr_d;
                        state_q <= IDLE;
                    end else if (count_q == lim_q) begin
                        done_q    <= 1'b1;
                        done_id_q <= sel_q;
                        state_q   <= DONE;
                    end else begin
                        count_q <= count_d;
                    end
                end
                DONE: begin
                    done_q    <= 1'b0;
                    done_id_q <= '0;
                    gnt_q     <= '0;
                    busy_q    <= 1'b0;
                    count_q   <= '0;
                    ptr_q     <= ptr_d;
                    state_q   <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign gnt_o     = gnt_q;
    assign busy_o    = busy_q;
    assign count_o   = count_q;
    assign done_o    = done_q;
    assign done_id_o = done_id_q;

endmodule

// File: tb/tb_count_sched.sv
// Scenario bench for count_sched: each task drives one scenario and checks inline,
// while a monitor pops expected completions from a scoreboard on every done pulse.
module tb_count_sched;

    localparam int N   = 4;
    localparam int W   = 16;
    localparam int IDW = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] req_limit = '0;
    logic [N-1:0]   gnt;
    logic           busy;
    logic [W-1:0]   count;
    logic           done;
    logic [IDW-1:0] done_id;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [IDW-1:0] id;
        logic [W-1:0]   lim;
    } exp_t;

    exp_t sb[$];

    count_sched #(
        .N   (N),
        .W   (W),
        .IDW (IDW)
    ) dut (
        .clock_i     (clk),
        .reset_ni    (rst_n),
        .req_i       (req),
        .req_limit_i (req_limit),
        .gnt_o       (gnt),
        .busy_o      (busy),
        .count_o     (count),
        .done_o      (done),
        .done_id_o   (done_id)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Monitor: invariants every cycle, scoreboard pop on each done pulse.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            checks++;
            if (((gnt & (gnt - 4'd1)) !== 4'd0) || (busy !== (|gnt)) || (done === 1'b1 && busy !== 1'b1)) begin
                failures++;
                $display("FAIL invariant: gnt=%b busy=%b done=%b", gnt, busy, done);
            end
            if (done === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_done: done_id=%0d with no expected completion", done_id);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (done_id !== e.id || count !== e.lim) begin
                        failures++;
                        $display("FAIL done_sb: got id=%0d count=%h, expected id=%0d count=%h",
                                 done_id, count, e.id, e.lim);
                    end
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic set_lim(input int i, input logic [W-1:0] v);
        req_limit[i*W +: W] = v;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req = '0;
        req_limit = '0;
        repeat (2) step();
        rst_n = 1'b1;
    endtask

    task automatic wait_done(input int maxc, output int n, output bit ok);
        n = 0;
        ok = 1'b0;
        while (n < maxc) begin
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
            step();
            n++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        checks++;
        if (gnt !== 4'd0 || busy !== 1'b0 || count !== 16'd0 || done !== 1'b0 || done_id !== 2'd0) begin
            failures++;
            $display("FAIL reset_state: gnt=%b busy=%b count=%h done=%b id=%0d, expected all zero",
                     gnt, busy, count, done, done_id);
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (gnt !== 4'd0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_no_req: gnt=%b busy=%b, expected 0/0", gnt, busy);
        end
    endtask

    task automatic test_single();
        do_reset();
        set_lim(0, 16'd6);
        req = 4'b0001;
        sb.push_back('{id: 2'd0, lim: 16'd6});
        step();
        checks++;
        if (gnt !== 4'b0001 || busy !== 1'b1 || count !== 16'd0) begin
            failures++;
            $display("FAIL single_grant: gnt=%b busy=%b count=%h, expected 0001/1/0", gnt, busy, count);
        end
        for (int k = 1; k <= 6; k++) begin
            step();
            checks++;
            if (count !== W'(k) || gnt !== 4'b0001 || done !== 1'b0) begin
                failures++;
                $display("FAIL single_count: count=%h gnt=%b done=%b, expected %h/0001/0", count, gnt, done, k);
            end
        end
        step();
        checks++;
        if (done !== 1'b1 || done_id !== 2'd0 || gnt !== 4'b0001) begin
            failures++;
            $display("FAIL single_done: done=%b id=%0d gnt=%b, expected 1/0/0001", done, done_id, gnt);
        end
        req = '0;
        step();
        checks++;
        if (gnt !== 4'd0 || busy !== 1'b0 || count !== 16'd0 || done !== 1'b0) begin
            failures++;
            $display("FAIL single_release: gnt=%b busy=%b count=%h done=%b, expected zeros", gnt, busy, count, done);
        end
    endtask

    task automatic test_fairness();
        int waited;
        int held;
        do_reset();
        for (int i = 0; i < N; i++) set_lim(i, 16'd2);
        for (int i = 0; i < N; i++) sb.push_back('{id: IDW'(i), lim: 16'd2});
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            waited = 0;
            while (gnt === 4'd0 && waited < 10) begin
                step();
                waited++;
            end
            checks++;
            if (gnt !== (4'b0001 << (g % 4)) || waited != 1) begin
                failures++;
                $display("FAIL fair_grant%0d: gnt=%b after %0d cycles, expected %b after 1",
                         g, gnt, waited, 4'b0001 << (g % 4));
            end
            if (g == 4) begin
                req = '0;
                step();
                checks++;
                if (gnt !== 4'd0 || done !== 1'b0) begin
                    failures++;
                    $display("FAIL fair_abandon: gnt=%b done=%b, expected 0/0", gnt, done);
                end
            end else begin
                held = 0;
                while (gnt !== 4'd0 && held < 20) begin
                    step();
                    held++;
                end
                checks++;
                if (held != 4) begin
                    failures++;
                    $display("FAIL fair_hold%0d: held %0d cycles, expected 4", g, held);
                end
            end
        end
    endtask

    task automatic test_limit0();
        do_reset();
        set_lim(0, 16'd0);
        req = 4'b0001;
        sb.push_back('{id: 2'd0, lim: 16'd0});
        step();
        checks++;
        if (gnt !== 4'b0001 || count !== 16'd0 || done !== 1'b0) begin
            failures++;
            $display("FAIL lim0_run: gnt=%b count=%h done=%b, expected 0001/0/0", gnt, count, done);
        end
        step();
        checks++;
        if (done !== 1'b1 || count !== 16'd0) begin
            failures++;
            $display("FAIL lim0_done: done=%b count=%h, expected 1/0", done, count);
        end
        req = '0;
        step();
    endtask

    task automatic test_limit_max();
        int n;
        bit bad;
        logic [W-1:0] prev;
        do_reset();
        set_lim(1, 16'hFFFF);
        req = 4'b0010;
        sb.push_back('{id: 2'd1, lim: 16'hFFFF});
        step();
        checks++;
        if (gnt !== 4'b0010 || count !== 16'd0) begin
            failures++;
            $display("FAIL max_grant: gnt=%b count=%h, expected 0010/0", gnt, count);
        end
        n = 0;
        bad = 1'b0;
        prev = count;
        while (done !== 1'b1 && n < 70000) begin
            step();
            n++;
            if (done !== 1'b1 && count !== prev + 16'd1) bad = 1'b1;
            prev = count;
        end
        checks++;
        if (bad || n != 65536 || count !== 16'hFFFF) begin
            failures++;
            $display("FAIL max_count: done after %0d cycles count=%h stepping_error=%0d, expected 65536/ffff/0",
                     n, count, bad);
        end
        req = '0;
        step();
    endtask

    task automatic test_abandon();
        int n;
        bit ok;
        do_reset();
        set_lim(0, 16'd10);
        set_lim(1, 16'd3);
        req = 4'b0011;
        sb.push_back('{id: 2'd1, lim: 16'd3});
        step();
        repeat (4) step();
        checks++;
        if (gnt !== 4'b0001 || count !== 16'd4) begin
            failures++;
            $display("FAIL abandon_pre: gnt=%b count=%h, expected 0001/4", gnt, count);
        end
        req = 4'b0010;
        step();
        checks++;
        if (gnt !== 4'd0 || busy !== 1'b0 || count !== 16'd0 || done !== 1'b0) begin
            failures++;
            $display("FAIL abandon_release: gnt=%b busy=%b count=%h done=%b, expected zeros", gnt, busy, count, done);
        end
        step();
        checks++;
        if (gnt !== 4'b0010 || count !== 16'd0) begin
            failures++;
            $display("FAIL abandon_next: gnt=%b count=%h, expected 0010/0", gnt, count);
        end
        wait_done(20, n, ok);
        checks++;
        if (!ok || n != 4) begin
            failures++;
            $display("FAIL abandon_next_done: ok=%0d after %0d cycles, expected done after 4", ok, n);
        end
        req = '0;
        step();
    endtask

    task automatic test_limit_change();
        int n;
        bit ok;
        do_reset();
        set_lim(0, 16'd6);
        req = 4'b0001;
        sb.push_back('{id: 2'd0, lim: 16'd6});
        step();
        step();
        set_lim(0, 16'd3);
        wait_done(20, n, ok);
        checks++;
        if (!ok || n != 6) begin
            failures++;
            $display("FAIL limchg_done: ok=%0d after %0d more cycles, expected done after 6", ok, n);
        end
        req = '0;
        step();
    endtask

    task automatic test_async_reset();
        do_reset();
        set_lim(0, 16'd10);
        req = 4'b0001;
        step();
        repeat (3) step();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (gnt !== 4'd0 || busy !== 1'b0 || count !== 16'd0 || done !== 1'b0) begin
            failures++;
            $display("FAIL async_clear: gnt=%b busy=%b count=%h done=%b, expected zeros before edge",
                     gnt, busy, count, done);
        end
        step();
        step();
        req = 4'b0110;
        set_lim(1, 16'd5);
        set_lim(2, 16'd5);
        rst_n = 1'b1;
        step();
        checks++;
        if (gnt !== 4'b0010 || count !== 16'd0) begin
            failures++;
            $display("FAIL async_first_grant: gnt=%b count=%h, expected 0010/0", gnt, count);
        end
        req = '0;
        step();
        checks++;
        if (gnt !== 4'd0 || done !== 1'b0) begin
            failures++;
            $display("FAIL async_drop: gnt=%b done=%b, expected 0/0", gnt, done);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_limit0();
        test_limit_max();
        test_abandon();
        test_limit_change();
        test_async_reset();
        repeat (2) step();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_drain: %0d expected completions never seen, expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
